axi_write_req_gen: RTL and testbench

//  Upstream write-request sequencer for the Write_Channel master/slave ILA pair.

---
 rtl/axi_write_req_gen.sv | 171 +++++++++++++++++
 tb/tb_axi_write_req_gen.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_write_req_gen.sv
// AXI write-request sequencer: takes one burst command and drives the AW, W and B
// handshakes, then pulses done with the response status.
// Optional feature macro: AW_W_OVERLAP_EN lets W beats run alongside the AW phase.
module axi_write_req_gen #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 64
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            start,
  input  logic [AW-1:0]   cfg_addr,
  input  logic [7:0]      cfg_len,
  input  logic [2:0]      cfg_size,
  input  logic [1:0]      cfg_burst,
  input  logic [DW-1:0]   cfg_seed,
  output logic [AW-1:0]   awaddr,
  output logic [7:0]      awlen,
  output logic [2:0]      awsize,
  output logic [1:0]      awburst,
  output logic            awvalid,
  input  logic            awready,
  output logic [DW-1:0]   wdata,
  output logic [DW/8-1:0] wstrb,
  output logic            wlast,
  output logic            wvalid,
  input  logic            wready,
  input  logic            bvalid,
  input  logic [1:0]      bresp,
  output logic            bready,
  output logic            busy,
  output logic            done,
  output logic            err
);

  localparam int unsigned SW          = DW / 8;
  localparam int unsigned MaxSizeInt  = $clog2(SW);
  localparam logic [2:0]  MaxSize     = 3'(MaxSizeInt);

  typedef enum logic [1:0] {StIdle, StAw, StW, StB} state_e;

  state_e          state_q, state_d;
  logic [7:0]      beat_q, beat_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [7:0]      len_q, len_d;
  logic [2:0]      size_q, size_d;
  logic [1:0]      burst_q, burst_d;
  logic [DW-1:0]   seed_q, seed_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic            aw_done_q, aw_done_d;
  logic            w_done_q, w_done_d;

  logic aw_hs, w_hs, b_hs, accept;
  logic unused_bresp0;

  assign aw_hs         = awvalid & awready;
  assign w_hs          = wvalid & wready;
  assign b_hs          = bvalid & bready;
  assign accept        = (state_q == StIdle) & start;
  // Only the error bit of the response matters here.
  assign unused_bresp0 = bresp[0];

  // State and datapath registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= StIdle;
      beat_q    <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      size_q    <= '0;
      burst_q   <= '0;
      seed_q    <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      size_q    <= size_d;
      burst_q   <= burst_d;
      seed_q    <= seed_d;
      done_q    <= done_d;
      err_q     <= err_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (start) state_d = StAw;
`ifdef AW_W_OVERLAP_EN
      // Both channels may finish in the same cycle; B waits for whichever is later.
      StAw: if ((aw_done_q | aw_hs) & (w_done_q | (w_hs & wlast))) state_d = StB;
`else
      StAw: if (aw_hs) state_d = StW;
`endif
      StW:    if (w_hs & wlast) state_d = StB;
      StB:    if (b_hs) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Command latch, beat counter, completion flags and response status
  always_comb begin
    addr_d    = addr_q;
    len_d     = len_q;
    size_d    = size_q;
    burst_d   = burst_q;
    seed_d    = seed_q;
    beat_d    = beat_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    done_d    = b_hs;
    err_d     = b_hs ? bresp[1] : err_q;
    if (accept) begin
      addr_d    = cfg_addr;
      len_d     = cfg_len;
      size_d    = (cfg_size > MaxSize) ? MaxSize : cfg_size;
      burst_d   = cfg_burst;
      seed_d    = cfg_seed;
      beat_d    = '0;
      aw_done_d = 1'b0;
      w_done_d  = 1'b0;
    end else begin
      // Wraps to 0 after beat 255, but wvalid is already low by then.
      if (w_hs) beat_d = beat_q + 8'd1;
      if (aw_hs) aw_done_d = 1'b1;
      if (w_hs & wlast) w_done_d = 1'b1;
    end
  end

  // Channel outputs decoded from state
  always_comb begin
    awvalid = 1'b0;
    wvalid  = 1'b0;
    bready  = 1'b0;
    unique case (state_q)
`ifdef AW_W_OVERLAP_EN
      StAw: begin
        awvalid = ~aw_done_q;
        wvalid  = ~w_done_q;
      end
`else
      StAw: awvalid = 1'b1;
`endif
      StW:  wvalid = 1'b1;
      StB:  bready = 1'b1;
      default: ;
    endcase
    busy  = (state_q != StIdle);
    wlast = wvalid & (beat_q == len_q);
    wdata = wvalid ? (seed_q + DW'(beat_q)) : '0;
    for (int unsigned i = 0; i < SW; i++) begin
      wstrb[i] = wvalid & (i < (32'd1 << size_q));
    end
  end

  assign awaddr  = addr_q;
  assign awlen   = len_q;
  assign awsize  = size_q;
  assign awburst = burst_q;
  assign done    = done_q;
  assign err     = err_q;

endmodule

// File: tb/tb_axi_write_req_gen.sv
// Self-checking bench for axi_write_req_gen: a scoreboard of expected W beats and
// responses is filled when commands are issued and drained by a negedge monitor.
module tb_axi_write_req_gen;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        start = 1'b0;
  logic [31:0] cfg_addr = '0;
  logic [7:0]  cfg_len = '0;
  logic [2:0]  cfg_size = '0;
  logic [1:0]  cfg_burst = '0;
  logic [63:0] cfg_seed = '0;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid, wlast, wvalid, bready, busy, done, err;
  logic        awready = 1'b0, wready = 1'b0, bvalid = 1'b0;
  logic [1:0]  bresp = '0;
  logic [63:0] wdata;
  logic [7:0]  wstrb;

  axi_write_req_gen #(.AW(32), .DW(64)) dut (
    .clk(clk), .resetn(resetn), .start(start),
    .cfg_addr(cfg_addr), .cfg_len(cfg_len), .cfg_size(cfg_size), .cfg_burst(cfg_burst),
    .cfg_seed(cfg_seed),
    .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bresp(bresp), .bready(bready),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] d;
    logic [7:0]  s;
    logic        l;
  } beat_t;

  beat_t exp_w[$];
  logic  exp_e[$];

  int checks = 0;
  int errors = 0;
  int aw_cnt = 0, w_cnt = 0, done_cnt = 0;
  int aw_wait_obs = 0, wv_aw_obs = 0;
  logic aw_seen = 1'b0;
  logic prev_bhs = 1'b0;

  logic [31:0] exp_addr = '0;
  logic [7:0]  exp_len = '0;
  logic [2:0]  exp_size = '0;
  logic [1:0]  exp_burst = '0;

  // Responder knobs
  int         aw_delay = 0;
  logic       wr_toggle = 1'b0;
  logic [1:0] bresp_val = 2'b00;
  int         aw_wait_cnt = 0;

  // Slave-side responder: drives ready/response just after each rising edge
  always @(posedge clk) begin
    #1;
    if (awvalid) begin
      awready = (aw_wait_cnt >= aw_delay);
      aw_wait_cnt++;
    end else begin
      awready = 1'b0;
      aw_wait_cnt = 0;
    end
    wready = wr_toggle ? ~wready : 1'b1;
    bvalid = bready;
    bresp  = bready ? bresp_val : 2'b00;
  end

  // Monitor: samples mid-cycle, compares against scoreboard
  always @(negedge clk) begin
    if (resetn) begin
      if (awvalid) begin
        checks++;
        if ({awaddr, awlen, awsize, awburst} !== {exp_addr, exp_len, exp_size, exp_burst}) begin
          errors++;
          $display("FAIL aw_payload: got %h/%h/%h/%h want %h/%h/%h/%h", awaddr, awlen, awsize,
                   awburst, exp_addr, exp_len, exp_size, exp_burst);
        end
        if (!awready) begin
          aw_wait_obs++;
          if (wvalid) wv_aw_obs++;
        end else begin
          aw_cnt++;
          aw_seen = 1'b1;
        end
      end
`ifndef AW_W_OVERLAP_EN
      if (wvalid) begin
        checks++;
        if (!aw_seen) begin
          errors++;
          $display("FAIL w_before_aw: wvalid=1 got before AW handshake, want 0");
        end
      end
`endif
      if (wvalid) begin
        checks++;
        if (exp_w.size() == 0) begin
          errors++;
          $display("FAIL w_unexpected: beat data %h with empty scoreboard", wdata);
        end else begin
          if ({wdata, wstrb, wlast} !== {exp_w[0].d, exp_w[0].s, exp_w[0].l}) begin
            errors++;
            $display("FAIL w_beat: got d=%h s=%h l=%b want d=%h s=%h l=%b", wdata, wstrb, wlast,
                     exp_w[0].d, exp_w[0].s, exp_w[0].l);
          end
          if (wready) begin
            void'(exp_w.pop_front());
            w_cnt++;
          end
        end
      end
      if (prev_bhs || done) begin
        checks++;
        if (done !== prev_bhs) begin
          errors++;
          $display("FAIL done_timing: done=%b want %b", done, prev_bhs);
        end
      end
      if (done) begin
        done_cnt++;
        checks++;
        if (exp_e.size() == 0) begin
          errors++;
          $display("FAIL done_unexpected: done=1 with no command outstanding");
        end else begin
          if (err !== exp_e[0]) begin
            errors++;
            $display("FAIL err: got %b want %b", err, exp_e[0]);
          end
          void'(exp_e.pop_front());
        end
      end
      prev_bhs = bvalid && bready;
    end else begin
      prev_bhs = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue a 1-cycle start and load scoreboard expectations; call at posedge+1
  task automatic start_cmd(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input logic [63:0] seed);
    logic [2:0] cs;
    beat_t b;
    cs = (size > 3'd3) ? 3'd3 : size;
    exp_addr = addr;
    exp_len = len;
    exp_size = cs;
    exp_burst = burst;
    aw_seen = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      b.d = seed + 64'(i);
      for (int j = 0; j < 8; j++) b.s[j] = (j < (1 << cs));
      b.l = (i == int'(len));
      exp_w.push_back(b);
    end
    exp_e.push_back(bresp_val[1]);
    cfg_addr = addr;
    cfg_len = len;
    cfg_size = size;
    cfg_burst = burst;
    cfg_seed = seed;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int base, input string name);
    int t;
    t = 0;
    while (done_cnt == base && t < 3000) begin
      step();
      t++;
    end
    checks++;
    if (done_cnt == base) begin
      errors++;
      $display("FAIL %s_timeout: done count %0d, want %0d", name, done_cnt, base + 1);
    end
    checks++;
    if (exp_w.size() != 0) begin
      errors++;
      $display("FAIL %s_beats_left: %0d beats outstanding, want 0", name, exp_w.size());
    end
  endtask

  task automatic test_reset();
    #2 resetn = 1'b0;
    #20;
    checks++;
    if ({awaddr, awlen, awsize, awburst, awvalid, wdata, wstrb, wlast, wvalid, bready, busy,
         done, err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b awvalid=%b wvalid=%b, want all outputs 0",
               busy, awvalid, wvalid);
    end
    @(negedge clk);
    resetn = 1'b1;
    step();
  endtask

  task automatic test_single_beat();
    int a0, w0, d0;
    a0 = aw_cnt; w0 = w_cnt; d0 = done_cnt;
    aw_delay = 0; wr_toggle = 1'b0; bresp_val = 2'b00;
    start_cmd(32'h1000, 8'd0, 3'd3, 2'b01, 64'h10);
    wait_done(d0, "single");
    checks++;
    if (aw_cnt - a0 != 1 || w_cnt - w0 != 1) begin
      errors++;
      $display("FAIL single_counts: aw=%0d w=%0d want 1/1", aw_cnt - a0, w_cnt - w0);
    end
  endtask

  task automatic test_wready_toggle();
    int w0, d0;
    w0 = w_cnt; d0 = done_cnt;
    wr_toggle = 1'b1;
    start_cmd(32'h2000, 8'd3, 3'd3, 2'b01, 64'h10);
    wait_done(d0, "toggle");
    wr_toggle = 1'b0;
    checks++;
    if (w_cnt - w0 != 4) begin
      errors++;
      $display("FAIL toggle_count: %0d handshakes, want 4", w_cnt - w0);
    end
  endtask

  task automatic test_aw_delay();
    int d0;
    d0 = done_cnt;
    aw_wait_obs = 0; wv_aw_obs = 0; aw_delay = 5;
    start_cmd(32'h3000, 8'd7, 3'd2, 2'b00, 64'h200);
    wait_done(d0, "awdelay");
    aw_delay = 0;
    checks++;
    if (aw_wait_obs != 5) begin
      errors++;
      $display("FAIL aw_wait: awvalid waited %0d cycles, want 5", aw_wait_obs);
    end
    checks++;
`ifdef AW_W_OVERLAP_EN
    if (wv_aw_obs != 5) begin
      errors++;
      $display("FAIL overlap_w: wvalid high %0d of the AW wait cycles, want 5", wv_aw_obs);
    end
`else
    if (wv_aw_obs != 0) begin
      errors++;
      $display("FAIL strict_w: wvalid high %0d of the AW wait cycles, want 0", wv_aw_obs);
    end
`endif
  endtask

  task automatic test_err_and_busy_start();
    int a0, d0;
    a0 = aw_cnt; d0 = done_cnt;
    aw_delay = 3; bresp_val = 2'b10;
    start_cmd(32'h4000, 8'd2, 3'd3, 2'b01, 64'h40);
    step();
    cfg_addr = 32'hDEAD_0000;
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done(d0, "err");
    aw_delay = 0;
    checks++;
    if (aw_cnt - a0 != 1) begin
      errors++;
      $display("FAIL busy_start: %0d AW handshakes, want 1", aw_cnt - a0);
    end
    step();
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL err_hold: err=%b want 1", err);
    end
    bresp_val = 2'b00;
    d0 = done_cnt;
    start_cmd(32'h4100, 8'd1, 3'd7, 2'b10, 64'h80);
    wait_done(d0, "err_clear");
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL err_clear: err=%b want 0", err);
    end
  endtask

  task automatic test_back_to_back();
    int t, d0;
    d0 = done_cnt;
    start_cmd(32'h5000, 8'd1, 3'd3, 2'b01, 64'h500);
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!(bvalid && bready) && t < 200);
    @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL b2b_done: done=%b want 1", done);
    end
    start_cmd(32'h5100, 8'd2, 3'd3, 2'b01, 64'h600);
    checks++;
    if (awvalid !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept: awvalid=%b busy=%b want 1/1", awvalid, busy);
    end
    wait_done(d0 + 1, "b2b");
  endtask

  task automatic test_reset_mid_burst();
    int t, w0, d0;
    w0 = w_cnt;
    start_cmd(32'h6000, 8'd7, 3'd3, 2'b01, 64'h700);
    t = 0;
    while (w_cnt - w0 < 2 && t < 100) begin
      @(negedge clk);
      t++;
    end
    @(posedge clk);
    #3;
    resetn = 1'b0;
    #1;
    checks++;
    if ({awaddr, awlen, awsize, awburst, awvalid, wdata, wstrb, wlast, wvalid, bready, busy,
         done, err} !== '0) begin
      errors++;
      $display("FAIL reset_mid: busy=%b wvalid=%b wdata=%h, want all outputs 0",
               busy, wvalid, wdata);
    end
    exp_w.delete();
    exp_e.delete();
    step();
    step();
    resetn = 1'b1;
    step();
    w0 = w_cnt; d0 = done_cnt;
    start_cmd(32'h6100, 8'd1, 3'd3, 2'b01, 64'h55);
    wait_done(d0, "post_reset");
    checks++;
    if (w_cnt - w0 != 2) begin
      errors++;
      $display("FAIL post_reset_count: %0d beats, want 2", w_cnt - w0);
    end
  endtask

  task automatic test_long_burst();
    int w0, d0;
    w0 = w_cnt; d0 = done_cnt;
    start_cmd(32'h7000, 8'd255, 3'd0, 2'b01, 64'hFFFF_FFFF_FFFF_FFC0);
    wait_done(d0, "long");
    repeat (3) step();
    checks++;
    if (w_cnt - w0 != 256 || done_cnt - d0 != 1) begin
      errors++;
      $display("FAIL long_counts: beats=%0d dones=%0d want 256/1", w_cnt - w0, done_cnt - d0);
    end
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_wready_toggle();
    test_aw_delay();
    test_err_and_busy_start();
    test_back_to_back();
    test_reset_mid_burst();
    test_long_burst();
    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
